// File: rtl/pll_lock_detect_if.sv
// ============================================================================
// Module  : pll_lock_detect_if
// Brief   : Monitored-clock input and lock status outputs of pll_lock_detect.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pll_lock_detect_if;
    logic       clk_div_in;
    logic       locked;
    logic       lock_lost;
    logic [3:0] half_period;
    logic [7:0] err_cnt;
    logic [1:0] state;

    modport master (
        output clk_div_in,
        input  locked, lock_lost, half_period, err_cnt, state
    );

    modport slave (
        input  clk_div_in,
        output locked, lock_lost, half_period, err_cnt, state
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_detect.sv
// ============================================================================
// Module  : pll_lock_detect
// Brief   : Measures half-periods of a divided PLL clock and tracks lock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pll_lock_detect #(
    parameter int HALF_PERIOD = 5,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int STALL_LIMIT = 15
) (
    input  wire logic        CLK,
    input  wire logic        reset,
    pll_lock_detect_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    localparam int          c_LO_RAW    = HALF_PERIOD - TOL;
    localparam logic [31:0] c_LO        = (c_LO_RAW < 1) ? 32'd1 : 32'(c_LO_RAW);
    localparam logic [31:0] c_HI        = 32'(HALF_PERIOD + TOL);
    localparam int          c_GW        = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [c_GW-1:0] c_LOCK_LAST = c_GW'(LOCK_COUNT - 1);
    localparam logic [3:0]  c_STALL     = 4'(STALL_LIMIT);

    logic            r_in_q;
    logic            r_in_d;
    logic [3:0]      r_run_len;
    logic            r_stall_seen;
    state_t          r_state;
    state_t          w_next_state;
    logic [c_GW-1:0] r_good_cnt;
    logic [c_GW-1:0] w_next_good_cnt;
    logic            r_locked;
    logic            r_lock_lost;
    logic [3:0]      r_half_period;
    logic [7:0]      r_err_cnt;
    logic            w_edge;
    logic            w_good;
    logic            w_stall;
    logic            w_err;
    logic            w_measure;
    logic [31:0]     w_meas;

    assign w_edge  = r_in_q ^ r_in_d;
    assign w_meas  = {28'd0, r_run_len};
    assign w_good  = (w_meas >= c_LO) && (w_meas <= c_HI);
    // An edge landing on the saturated count wins; the stall fires once until the next edge.
    assign w_stall = !w_edge && (r_run_len == c_STALL) && !r_stall_seen;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_in_q       <= 1'b0;
            r_in_d       <= 1'b0;
            r_run_len    <= 4'd0;
            r_stall_seen <= 1'b0;
        end else begin
            r_in_q <= bus.clk_div_in;
            r_in_d <= r_in_q;
            if (w_edge) begin
                r_run_len    <= 4'd1;
                r_stall_seen <= 1'b0;
            end else begin
                if (r_run_len < c_STALL) begin
                    r_run_len <= r_run_len + 4'd1;
                end
                if (w_stall) begin
                    r_stall_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_good_cnt <= w_next_good_cnt;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_good_cnt = r_good_cnt;
        w_err           = 1'b0;
        w_measure       = 1'b0;
        case (r_state)
            IDLE: begin
                // First edge after idle closes a partial period and is not measured.
                if (w_edge) begin
                    w_next_state    = ACQUIRE;
                    w_next_good_cnt = '0;
                end
            end
            ACQUIRE: begin
                if (w_edge) begin
                    w_measure = 1'b1;
                    if (w_good) begin
                        w_next_good_cnt = r_good_cnt + c_GW'(1);
                        if (r_good_cnt == c_LOCK_LAST) begin
                            w_next_state = LOCKED;
                        end
                    end else begin
                        w_next_good_cnt = '0;
                        w_err           = 1'b1;
                    end
                end else if (w_stall) begin
                    w_next_state    = IDLE;
                    w_next_good_cnt = '0;
                    w_err           = 1'b1;
                end
            end
            LOCKED: begin
                if (w_edge) begin
                    w_measure = 1'b1;
                    if (!w_good) begin
                        w_next_state    = ACQUIRE;
                        w_next_good_cnt = '0;
                        w_err           = 1'b1;
                    end
                end else if (w_stall) begin
                    w_next_state    = IDLE;
                    w_next_good_cnt = '0;
                    w_err           = 1'b1;
                end
            end
            default: begin
                w_next_state    = IDLE;
                w_next_good_cnt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_locked      <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_half_period <= 4'd0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_locked    <= (w_next_state == LOCKED);
            r_lock_lost <= (r_state == LOCKED) && (w_next_state != LOCKED);
            if (w_measure) begin
                r_half_period <= r_run_len;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign bus.locked      = r_locked;
    assign bus.lock_lost   = r_lock_lost;
    assign bus.half_period = r_half_period;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_detect.sv
// ============================================================================
// Module  : tb_pll_lock_detect
// Brief   : Directed bench for pll_lock_detect (default and TOL=1 instances).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_detect;
    logic        CLK = 1'b0;
    logic        reset;
    logic        div;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] st0;
    logic [15:0] st1;
    logic [15:0] exp_st;

    pll_lock_detect_if bus0 ();
    pll_lock_detect_if bus1 ();

    assign bus0.clk_div_in = div;
    assign bus1.clk_div_in = div;

    // Status word: {state, locked, lock_lost, half_period, err_cnt}
    assign st0 = {bus0.state, bus0.locked, bus0.lock_lost, bus0.half_period, bus0.err_cnt};
    assign st1 = {bus1.state, bus1.locked, bus1.lock_lost, bus1.half_period, bus1.err_cnt};

    pll_lock_detect dut0 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus0)
    );

    pll_lock_detect #(.TOL(1)) dut1 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 CLK = ~CLK;

    // Toggle the monitored clock and hold the new level for n CLK cycles.
    task automatic half(input int n);
        div = ~div;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        div   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    task automatic acquire_lock(input string tag);
        repeat (4) half(5);
        exp_st = {2'b01, 1'b0, 1'b0, 4'd5, 8'd0};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL %s_prelock: status=%h expected %h", tag, st0, exp_st);
        end
        div = ~div;
        @(posedge CLK); #1;
        checks++;
        if (bus0.locked !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: locked=%b expected 0", tag, bus0.locked);
        end
        @(posedge CLK); #1;
        exp_st = {2'b10, 1'b1, 1'b0, 4'd5, 8'd0};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL %s_rise: status=%h expected %h", tag, st0, exp_st);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        div   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (st0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dut0: status=%h expected 0000", st0);
        end
        checks++;
        if (st1 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dut1: status=%h expected 0000", st1);
        end
        reset = 1'b0;
    endtask

    task automatic test_acquire();
        acquire_lock("acquire");
    endtask

    task automatic test_lock_loss();
        half(7);
        exp_st = {2'b10, 1'b1, 1'b0, 4'd5, 8'd0};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL loss_hold: status=%h expected %h", st0, exp_st);
        end
        div = ~div;
        @(posedge CLK); #1;
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL loss_edge: status=%h expected %h", st0, exp_st);
        end
        @(posedge CLK); #1;
        exp_st = {2'b01, 1'b0, 1'b1, 4'd7, 8'd1};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL loss_drop: status=%h expected %h", st0, exp_st);
        end
        @(posedge CLK); #1;
        exp_st = {2'b01, 1'b0, 1'b0, 4'd7, 8'd1};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL loss_pulse_end: status=%h expected %h", st0, exp_st);
        end
        repeat (2) @(posedge CLK);
        #1;
        repeat (3) half(5);
        exp_st = {2'b01, 1'b0, 1'b0, 4'd5, 8'd1};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL relock_pre: status=%h expected %h", st0, exp_st);
        end
        half(5);
        exp_st = {2'b10, 1'b1, 1'b0, 4'd5, 8'd1};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL relock: status=%h expected %h", st0, exp_st);
        end
    endtask

    task automatic test_stall();
        int pulses = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (bus0.lock_lost === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL stall_pulses: lock_lost cycles=%0d expected 1", pulses);
        end
        exp_st = {2'b00, 1'b0, 1'b0, 4'd5, 8'd2};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL stall_state: status=%h expected %h", st0, exp_st);
        end
    endtask

    task automatic test_edge_priority();
        pulse_reset();
        half(5);
        half(15);
        half(5);
        exp_st = {2'b01, 1'b0, 1'b0, 4'd15, 8'd1};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL edge_at_limit: status=%h expected %h", st0, exp_st);
        end
        half(16);
        div = ~div;
        @(posedge CLK); #1;
        exp_st = {2'b00, 1'b0, 1'b0, 4'd5, 8'd2};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL stall_acquire: status=%h expected %h", st0, exp_st);
        end
        @(posedge CLK); #1;
        exp_st = {2'b01, 1'b0, 1'b0, 4'd5, 8'd2};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL discard_after_stall: status=%h expected %h", st0, exp_st);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic test_tolerance();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            half((i % 2 == 1) ? 6 : 4);
            if (i == 4) begin
                checks++;
                if (bus1.state !== 2'b10) begin
                    errors++;
                    $display("FAIL tol1_lock_time: state=%b expected 10", bus1.state);
                end
            end
        end
        exp_st = {2'b10, 1'b1, 1'b0, 4'd4, 8'd0};
        checks++;
        if (st1 !== exp_st) begin
            errors++;
            $display("FAIL tol1_locked: status=%h expected %h", st1, exp_st);
        end
        exp_st = {2'b01, 1'b0, 1'b0, 4'd4, 8'd9};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL tol0_nolock: status=%h expected %h", st0, exp_st);
        end
    endtask

    task automatic test_reset_while_locked();
        pulse_reset();
        acquire_lock("prereset");
        reset = 1'b1;
        div   = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (st0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_locked: status=%h expected 0000", st0);
        end
        reset = 1'b0;
        acquire_lock("postreset");
    endtask

    task automatic test_err_saturation();
        pulse_reset();
        repeat (255) half(3);
        checks++;
        if (bus0.err_cnt !== 8'd254) begin
            errors++;
            $display("FAIL err_254: err_cnt=%0d expected 254", bus0.err_cnt);
        end
        half(3);
        checks++;
        if (bus0.err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL err_255: err_cnt=%0d expected 255", bus0.err_cnt);
        end
        repeat (20) half(3);
        exp_st = {2'b01, 1'b0, 1'b0, 4'd3, 8'd255};
        checks++;
        if (st0 !== exp_st) begin
            errors++;
            $display("FAIL err_hold: status=%h expected %h", st0, exp_st);
        end
    endtask

    initial begin
        reset = 1'b1;
        div   = 1'b0;
        test_reset();
        test_acquire();
        test_lock_loss();
        test_stall();
        test_edge_priority();
        test_tolerance();
        test_reset_while_locked();
        test_err_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
